pixel_sort_desc_iter: RTL and testbench

- Iterative descending sorter for 8 unsigned pixels. It is the reverse-order counterpart to the ascending pixel sorter.
- Captures one 8-pixel window on `enable`, then runs an odd-even transposition sort, one phase per clock.
- Presents the pixels largest-first, together with each pixel's original input position, for rank/median post-processing.
- Sits beside the ascending sorter in the pixel_sorting datapath. It trades throughput (one window per 10 cycles) for a single row of 4 comparators.

---
 rtl/pixel_sort_desc_iter.sv | 149 ++++++++++++++
 tb/tb_pixel_sort_desc_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sort_desc_iter.sv
// rtl/pixel_sort_desc_iter.sv - iterative odd-even transposition sorter, 8 pixels, largest first
module pixel_sort_desc_iter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] Pixel_in1,
    input  logic [DATA_W-1:0] Pixel_in2,
    input  logic [DATA_W-1:0] Pixel_in3,
    input  logic [DATA_W-1:0] Pixel_in4,
    input  logic [DATA_W-1:0] Pixel_in5,
    input  logic [DATA_W-1:0] Pixel_in6,
    input  logic [DATA_W-1:0] Pixel_in7,
    input  logic [DATA_W-1:0] Pixel_in8,
    output logic [DATA_W-1:0] Pixel_out1,
    output logic [DATA_W-1:0] Pixel_out2,
    output logic [DATA_W-1:0] Pixel_out3,
    output logic [DATA_W-1:0] Pixel_out4,
    output logic [DATA_W-1:0] Pixel_out5,
    output logic [DATA_W-1:0] Pixel_out6,
    output logic [DATA_W-1:0] Pixel_out7,
    output logic [DATA_W-1:0] Pixel_out8,
    output logic [2:0]        Index_out1,
    output logic [2:0]        Index_out2,
    output logic [2:0]        Index_out3,
    output logic [2:0]        Index_out4,
    output logic [2:0]        Index_out5,
    output logic [2:0]        Index_out6,
    output logic [2:0]        Index_out7,
    output logic [2:0]        Index_out8,
    output logic              valid_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t            state;
    logic [2:0]        p;
    logic [DATA_W-1:0] pin [8];
    logic [DATA_W-1:0] v   [8];
    logic [DATA_W-1:0] nv  [8];
    logic [DATA_W-1:0] po  [8];
    logic [2:0]        ix  [8];
    logic [2:0]        nix [8];
    logic [2:0]        pi  [8];

    assign pin[0] = Pixel_in1;
    assign pin[1] = Pixel_in2;
    assign pin[2] = Pixel_in3;
    assign pin[3] = Pixel_in4;
    assign pin[4] = Pixel_in5;
    assign pin[5] = Pixel_in6;
    assign pin[6] = Pixel_in7;
    assign pin[7] = Pixel_in8;

    // One phase of the network; strict compare keeps equal pixels in input order.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nv[i]  = v[i];
            nix[i] = ix[i];
        end
        if (!p[0]) begin
            for (int k = 0; k < 4; k++) begin
                if (v[2*k] < v[2*k+1]) begin
                    nv[2*k]    = v[2*k+1];
                    nv[2*k+1]  = v[2*k];
                    nix[2*k]   = ix[2*k+1];
                    nix[2*k+1] = ix[2*k];
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (v[2*k+1] < v[2*k+2]) begin
                    nv[2*k+1]  = v[2*k+2];
                    nv[2*k+2]  = v[2*k+1];
                    nix[2*k+1] = ix[2*k+2];
                    nix[2*k+2] = ix[2*k+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            p         <= 3'd0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                v[i]  <= '0;
                ix[i] <= 3'd0;
                po[i] <= '0;
                pi[i] <= 3'd0;
            end
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        for (int i = 0; i < 8; i++) begin
                            v[i]  <= pin[i];
                            ix[i] <= 3'(i);
                        end
                        p     <= 3'd0;
                        busy  <= 1'b1;
                        state <= SORT;
                    end
                end
                SORT: begin
                    for (int i = 0; i < 8; i++) begin
                        v[i]  <= nv[i];
                        ix[i] <= nix[i];
                    end
                    p <= p + 3'd1;
                    if (p == 3'd7) state <= DONE;
                end
                DONE: begin
                    for (int i = 0; i < 8; i++) begin
                        po[i] <= v[i];
                        pi[i] <= ix[i];
                    end
                    valid_out <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Pixel_out1 = po[0];
    assign Pixel_out2 = po[1];
    assign Pixel_out3 = po[2];
    assign Pixel_out4 = po[3];
    assign Pixel_out5 = po[4];
    assign Pixel_out6 = po[5];
    assign Pixel_out7 = po[6];
    assign Pixel_out8 = po[7];
    assign Index_out1 = pi[0];
    assign Index_out2 = pi[1];
    assign Index_out3 = pi[2];
    assign Index_out4 = pi[3];
    assign Index_out5 = pi[4];
    assign Index_out6 = pi[5];
    assign Index_out7 = pi[6];
    assign Index_out8 = pi[7];

endmodule

// File: tb/tb_pixel_sort_desc_iter.sv
// tb/tb_pixel_sort_desc_iter.sv - self-checking bench for pixel_sort_desc_iter
module tb_pixel_sort_desc_iter;

    typedef logic [7:0][15:0] vec_t;
    typedef logic [7:0][2:0]  idx_t;

    typedef struct {
        string name;
        vec_t  in;
        vec_t  ep;
        idx_t  ei;
    } vector_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    vec_t pin_v;
    wire [7:0][15:0] po_w;
    wire [7:0][2:0]  pi_w;
    logic valid_out;
    logic busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pixel_sort_desc_iter #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .Pixel_in1(pin_v[0]), .Pixel_in2(pin_v[1]), .Pixel_in3(pin_v[2]), .Pixel_in4(pin_v[3]),
        .Pixel_in5(pin_v[4]), .Pixel_in6(pin_v[5]), .Pixel_in7(pin_v[6]), .Pixel_in8(pin_v[7]),
        .Pixel_out1(po_w[0]), .Pixel_out2(po_w[1]), .Pixel_out3(po_w[2]), .Pixel_out4(po_w[3]),
        .Pixel_out5(po_w[4]), .Pixel_out6(po_w[5]), .Pixel_out7(po_w[6]), .Pixel_out8(po_w[7]),
        .Index_out1(pi_w[0]), .Index_out2(pi_w[1]), .Index_out3(pi_w[2]), .Index_out4(pi_w[3]),
        .Index_out5(pi_w[4]), .Index_out6(pi_w[5]), .Index_out7(pi_w[6]), .Index_out8(pi_w[7]),
        .valid_out(valid_out), .busy(busy)
    );

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Element i lands at rank = number of larger elements plus equal elements ahead of it.
    task automatic model(input vec_t x, output vec_t ep, output idx_t ei);
        for (int i = 0; i < 8; i++) begin
            int r = 0;
            for (int j = 0; j < 8; j++)
                if (x[j] > x[i] || (x[j] == x[i] && j < i)) r++;
            ep[r] = x[i];
            ei[r] = 3'(i);
        end
    endtask

    function automatic vec_t mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        vec_t r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
        return r;
    endfunction

    function automatic idx_t mki(input int a0, a1, a2, a3, a4, a5, a6, a7);
        idx_t r;
        r[0] = 3'(a0); r[1] = 3'(a1); r[2] = 3'(a2); r[3] = 3'(a3);
        r[4] = 3'(a4); r[5] = 3'(a5); r[6] = 3'(a6); r[7] = 3'(a7);
        return r;
    endfunction

    function automatic vec_t rnd_vec(input bit narrow);
        vec_t r;
        for (int i = 0; i < 8; i++)
            r[i] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 65535));
        return r;
    endfunction

    task automatic check_out(input vec_t ep, input idx_t ei, input string name);
        for (int i = 0; i < 8; i++) begin
            chk(32'(po_w[i]), 32'(ep[i]), $sformatf("%s Pixel_out%0d", name, i + 1));
            chk(32'(pi_w[i]), 32'(ei[i]), $sformatf("%s Index_out%0d", name, i + 1));
        end
    endtask

    // Called idle, #1 after an edge; returns #1 after the edge following valid_out.
    task automatic do_sort(input vec_t x, input vec_t ep, input idx_t ei, input string name);
        int n;
        int bc;
        pin_v  = x;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        pin_v  = rnd_vec(1'b0);
        chk(32'(busy), 1, {name, " busy after capture"});
        n  = 0;
        bc = 1;
        while (!valid_out && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        chk(n, 9, {name, " latency"});
        chk(bc, 9, {name, " busy cycles"});
        check_out(ep, ei, name);
        @(posedge clk); #1;
        chk(32'(valid_out), 0, {name, " valid single pulse"});
        check_out(ep, ei, {name, " hold"});
    endtask

    vector_t tbl[4];
    vec_t    hist[25];

    initial begin
        vec_t ep;
        idx_t ei;
        int   vc;
        int   n;

        tbl[0] = '{"plan", mk8(55, 1037, 345, 345, 45, 234, 456, 344),
                   mk8(1037, 456, 345, 345, 344, 234, 55, 45), mki(1, 6, 2, 3, 7, 5, 0, 4)};
        tbl[1] = '{"equal", mk8('h1234, 'h1234, 'h1234, 'h1234, 'h1234, 'h1234, 'h1234, 'h1234),
                   mk8('h1234, 'h1234, 'h1234, 'h1234, 'h1234, 'h1234, 'h1234, 'h1234),
                   mki(0, 1, 2, 3, 4, 5, 6, 7)};
        tbl[2] = '{"unsigned", mk8(0, 'hFFFF, 1, 'h8000, 2, 'h7FFF, 3, 'hFFFE),
                   mk8('hFFFF, 'hFFFE, 'h8000, 'h7FFF, 3, 2, 1, 0), mki(1, 7, 3, 5, 6, 4, 2, 0)};
        tbl[3] = '{"ascending", mk8(1, 2, 3, 4, 5, 6, 7, 8),
                   mk8(8, 7, 6, 5, 4, 3, 2, 1), mki(7, 6, 5, 4, 3, 2, 1, 0)};

        reset  = 1'b1;
        enable = 1'b0;
        pin_v  = '0;
        @(posedge clk); #1;
        chk(32'(busy), 0, "reset busy");
        chk(32'(valid_out), 0, "reset valid_out");
        check_out('0, '0, "reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++)
            do_sort(tbl[t].in, tbl[t].ep, tbl[t].ei, tbl[t].name);

        for (int r = 0; r < 6; r++) begin
            vec_t x;
            x = rnd_vec(r[0]);
            model(x, ep, ei);
            do_sort(x, ep, ei, $sformatf("random%0d", r));
        end

        // enable held high, inputs changing every cycle
        vc = 0;
        for (int c = 0; c < 25; c++) begin
            pin_v   = rnd_vec(c[1]);
            enable  = 1'b1;
            hist[c] = pin_v;
            @(posedge clk); #1;
            if (valid_out) begin
                vc++;
                chk(c, (vc == 1) ? 9 : 19, $sformatf("b2b valid%0d edge", vc));
                if (c >= 9) begin
                    model(hist[c-9], ep, ei);
                    check_out(ep, ei, $sformatf("b2b result%0d", vc));
                end
            end
        end
        enable = 1'b0;
        chk(vc, 2, "b2b valid count");
        n = 0;
        while (!valid_out && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n, 5, "b2b third valid edge");
        model(hist[20], ep, ei);
        check_out(ep, ei, "b2b result3");
        @(posedge clk); #1;

        // reset four edges into a sort aborts it
        pin_v  = tbl[2].in;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk(32'(busy), 0, "abort busy");
        chk(32'(valid_out), 0, "abort valid_out");
        check_out('0, '0, "abort");
        vc = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (valid_out) vc++;
        end
        chk(vc, 0, "abort no valid");
        do_sort(tbl[0].in, tbl[0].ep, tbl[0].ei, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
